seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter SCAN_DIV, default 262144, clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter DIM_BITS, default 4, brightness resolution in bits (1..8).
REQ-004 SHALL have port clk, input, 1 bit, the single clock for all sequential logic.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port load, input, 1 bit, a one-cycle strobe that captures value and dp_in.
REQ-007 SHALL have port value, input, 4*DIGITS bits, hex nibbles; nibble i drives digit i, and digit DIGITS-1 is leftmost.
REQ-008 SHALL have port dp_in, input, DIGITS bits, per-digit decimal point, 1 = lit.
REQ-009 SHALL have port blank_lz, input, 1 bit, leading-zero blanking enable, sampled live.
REQ-010 SHALL have port bright, input, DIM_BITS bits, brightness duty setting, sampled live.
REQ-011 SHALL have port an, output, DIGITS bits, active-low anode selects.
REQ-012 SHALL have port seg, output, 7 bits, {a,b,c,d,e,f,g}, active-low.
REQ-013 SHALL have port dp, output, 1 bit, active-low decimal point.
REQ-014 SHALL have port pend, output, 1 bit, high while a loaded value awaits the frame boundary.
REQ-015 SHALL have port frame_done, output, 1 bit, one-cycle pulse at each frame boundary.

Function
REQ-016 SHALL run a slot counter 0..SCAN_DIV-1; at terminal count it wraps to 0 and advances the digit index.
REQ-017 SHALL scan the digit index DIGITS-1 down to 0, then wrap to DIGITS-1; frame length is DIGITS*SCAN_DIV cycles.
REQ-018 SHALL define the frame boundary as the cycle where slot counter = SCAN_DIV-1 and index = 0.
REQ-019 SHALL on load capture value/dp_in into a pending register and set pend; a later load before the boundary overwrites the pending register.
REQ-020 SHALL at the frame boundary copy pending into the display shadow register, clear pend, and pulse frame_done for that cycle.
REQ-021 SHALL, when load coincides with the boundary, transfer the load-cycle value directly into shadow and leave pend low.
REQ-022 SHALL never change shadow mid-frame, so no tearing occurs.
REQ-023 SHALL decode the shadow nibble as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
REQ-024 SHALL continue the decode as: 8=0000000, 9=0001100, A=0001000, b=1100000, c=1110010, d=1000010, E=0110000, F=0111000.
REQ-025 SHALL, with blank_lz=1, blank every zero digit above the most significant nonzero digit (an bit high, seg=1111111, dp=1); digit 0 is never blanked.
REQ-026 SHALL not blank a zero digit whose dp_in bit is set under leading-zero blanking; that digit and all digits below it display.
REQ-027 SHALL run a DIM_BITS-bit free-running PWM counter; the selected anode is enabled when bright is all-ones or the PWM count is less than bright.
REQ-028 SHALL, when bright=0, hold all anodes high and seg/dp at all-ones.
REQ-029 SHALL drive at most one an bit low in any cycle.
REQ-030 SHALL register an, seg and dp, giving one cycle of latency from index/PWM state to the pins.

Reset
REQ-031 SHALL on rst low asynchronously clear the slot and PWM counters, set the index to DIGITS-1, clear shadow, pending and pend, and clear frame_done.
REQ-032 SHALL on rst low drive an to all-ones, seg to 1111111 and dp to 1.
REQ-033 SHALL discard any pending load when rst is asserted mid-frame.
REQ-034 SHALL resume scanning at digit DIGITS-1 on the first clock after rst deasserts.

Verification (DIGITS=4, SCAN_DIV=4, DIM_BITS=2)
REQ-035 SHALL verify that, after reset with bright=3 and a load of 0x12AF, the first frame shows 0 on every digit and frame_done pulses at cycle 15.
REQ-036 SHALL verify that, continuing REQ-035, the next frame shows an 0111/seg 1001111, 1011/0010010, 1101/0001000, 1110/0111000.
REQ-037 SHALL verify that two loads (0x1111, then 0x2222) within one frame leave pend high until the boundary, and the next frame shows only 2s.
REQ-038 SHALL verify that value 0x0005 with blank_lz=1 never drives an[3:1] low, and digit 0 shows 0100100.
REQ-039 SHALL verify that value 0x0000 with blank_lz=1 and dp_in=0010 lights digits 1 and 0, with dp low only on digit 1.
REQ-040 SHALL verify that, with bright=1, each anode is low 1 of every 4 PWM cycles in its slot.
REQ-041 SHALL verify that, with bright=0, an stays at 1111.
REQ-042 SHALL verify that rst pulsed low mid-frame with pend high takes outputs to idle within the same cycle and leaves pend low afterwards.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: frame-synchronous value updates, leading-zero
// blanking and PWM brightness, with registered anode/segment/dp pins.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 262144,
    parameter int unsigned DIM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [DIM_BITS-1:0]   bright,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  pend,
    output logic                  frame_done
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] SlotLast = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxFirst = IW'(DIGITS - 1);

    logic [SW-1:0]         slot_q, slot_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DIM_BITS-1:0]   pwm_q, pwm_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_q, pend_d;
    logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  boundary;
    logic                  enable;
    logic                  lead;
    logic [DIGITS-1:0]     blank_vec;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic [DIGITS-1:0]     an_sel;
    logic [6:0]            seg_dec;

    assign boundary = (slot_q == SlotLast) && (idx_q == '0);

    // Scan timing and PWM
    always_comb begin
        slot_d = slot_q + SW'(1);
        idx_d  = idx_q;
        pwm_d  = pwm_q + DIM_BITS'(1);
        if (slot_q == SlotLast) begin
            slot_d = '0;
            idx_d  = (idx_q == '0) ? IdxFirst : idx_q - IW'(1);
        end
    end

    // A load on the boundary cycle bypasses the pending register.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_d       = pend_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (load && !boundary) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_d     = 1'b1;
        end
        if (boundary) begin
            pend_d = 1'b0;
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
            end else if (pend_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
        end
    end

    // A digit is blanked only while every digit from it upward is zero with no dp lit.
    always_comb begin
        lead      = 1'b1;
        blank_vec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead = lead & (shadow_val_q[4*i +: 4] == 4'h0) & ~shadow_dp_q[i];
            blank_vec[i] = blank_lz & lead & (i != 0);
        end
    end

    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib_sel   = shadow_val_q[4*i +: 4];
                dp_sel    = shadow_dp_q[i];
                blank_sel = blank_vec[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        seg_dec = 7'b1111111;
        unique case (nib_sel)
            4'h0: seg_dec = 7'b0000001;
            4'h1: seg_dec = 7'b1001111;
            4'h2: seg_dec = 7'b0010010;
            4'h3: seg_dec = 7'b0000110;
            4'h4: seg_dec = 7'b1001100;
            4'h5: seg_dec = 7'b0100100;
            4'h6: seg_dec = 7'b0100000;
            4'h7: seg_dec = 7'b0001111;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0001100;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b1100000;
            4'hC: seg_dec = 7'b1110010;
            4'hD: seg_dec = 7'b1000010;
            4'hE: seg_dec = 7'b0110000;
            4'hF: seg_dec = 7'b0111000;
            default: seg_dec = 7'b1111111;
        endcase
    end

    assign enable = (bright == '1) || (pwm_q < bright);

    always_comb begin
        an_d  = '1;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (enable && !blank_sel) begin
            an_d  = an_sel;
            seg_d = seg_dec;
            dp_d  = ~dp_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q       <= '0;
            idx_q        <= IdxFirst;
            pwm_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pend       = pend_q;
    assign frame_done = boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 4-digit, 4-cycle-slot, 2-bit-dim configuration.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [1:0]  bright = 2'd3;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pend;
    logic        frame_done;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpi;
        logic            blz;
        logic [3:0][3:0] an_e;
        logic [3:0][6:0] seg_e;
        logic [3:0]      dp_e;
    } vec_t;

    vec_t vecs[9];

    seg_scan_ctrl #(
        .DIGITS   (4),
        .SCAN_DIV (4),
        .DIM_BITS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .pend       (pend),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        chk("frame_wait", {31'd0, frame_done}, 32'd1);
    endtask

    // Samples each digit mid-slot across one display frame.
    task automatic sample_frame(input int lead, input logic [3:0][3:0] an_e,
                                input logic [3:0][6:0] seg_e, input logic [3:0] dp_e,
                                input string tag);
        repeat (lead) @(negedge clk);
        chk({tag, "_pend"}, {31'd0, pend}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            int d;
            d = 3 - k;
            chk($sformatf("%s_an%0d", tag, d), {28'd0, an}, {28'd0, an_e[d]});
            chk($sformatf("%s_seg%0d", tag, d), {25'd0, seg}, {25'd0, seg_e[d]});
            chk($sformatf("%s_dp%0d", tag, d), {31'd0, dp}, {31'd0, dp_e[d]});
            if (k < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic pwm_window(input logic [1:0] br, input int exp_cnt);
        int cnt[4];
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        @(negedge clk);
        bright = br;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("pwm%0d_onehot", br), {31'd0, ($countones(~an) <= 1)}, 32'd1);
            for (int d = 0; d < 4; d++) if (!an[d]) cnt[d]++;
            if (br == 2'd0) begin
                chk("dark_an", {28'd0, an}, 32'hF);
                chk("dark_seg", {25'd0, seg}, 32'h7F);
            end
        end
        for (int d = 0; d < 4; d++) chk($sformatf("pwm%0d_cnt%0d", br, d), cnt[d], exp_cnt);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1111};
        vecs[1] = '{16'h3456, 4'b0101, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000}, 4'b1010};
        vecs[2] = '{16'h789B, 4'b0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0001111, 7'b0000000, 7'b0001100, 7'b1100000}, 4'b1111};
        vecs[3] = '{16'hCDE0, 4'b1000, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1110010, 7'b1000010, 7'b0110000, 7'b0000001}, 4'b0111};
        vecs[4] = '{16'h0005, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 4'b1111};
        vecs[5] = '{16'h0000, 4'b0010, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b0000001, 7'b0000001}, 4'b1101};
        vecs[6] = '{16'h0F00, 4'b0000, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b0111000, 7'b0000001, 7'b0000001}, 4'b1111};
        vecs[7] = '{16'h0000, 4'b0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
        vecs[8] = '{16'h0000, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};

        // Reset state, then first frame (zeros) and second frame (0x12AF).
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_pend", {31'd0, pend}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_an", {28'd0, an}, 32'hF);
        load = 1'b1;
        value = 16'h12AF;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) load = 1'b0;
            chk($sformatf("f1_fd_c%0d", c), {31'd0, frame_done}, {31'd0, (c == 15)});
            chk($sformatf("f1_pend_c%0d", c), {31'd0, pend}, {31'd0, (c <= 15)});
            if (c >= 2 && c <= 14 && (c % 4) == 2) begin
                int d;
                d = 3 - (c - 2) / 4;
                chk($sformatf("f1_an%0d", d), {28'd0, an}, {28'd0, vecs[0].an_e[d]});
                chk($sformatf("f1_seg%0d", d), {25'd0, seg}, 32'h01);
                chk($sformatf("f1_dp%0d", d), {31'd0, dp}, 32'd1);
            end
            if (c >= 18 && (c % 4) == 2) begin
                int d;
                d = 3 - (c - 18) / 4;
                chk($sformatf("f2_an%0d", d), {28'd0, an}, {28'd0, vecs[0].an_e[d]});
                chk($sformatf("f2_seg%0d", d), {25'd0, seg}, {25'd0, vecs[0].seg_e[d]});
                chk($sformatf("f2_dp%0d", d), {31'd0, dp}, 32'd1);
            end
        end

        // Table-driven display vectors.
        for (int v = 0; v < 9; v++) begin
            wait_frame();
            @(negedge clk);
            load = 1'b1;
            value = vecs[v].val;
            dp_in = vecs[v].dpi;
            blank_lz = vecs[v].blz;
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("v%0d_pend_set", v), {31'd0, pend}, 32'd1);
            wait_frame();
            chk($sformatf("v%0d_pend_bnd", v), {31'd0, pend}, 32'd1);
            sample_frame(3, vecs[v].an_e, vecs[v].seg_e, vecs[v].dp_e, $sformatf("v%0d", v));
        end

        // Two loads in one frame: the later one wins.
        blank_lz = 1'b0;
        dp_in = 4'b0000;
        wait_frame();
        @(negedge clk);
        load = 1'b1;
        value = 16'h1111;
        @(negedge clk);
        load = 1'b0;
        chk("two_pend1", {31'd0, pend}, 32'd1);
        repeat (3) @(negedge clk);
        load = 1'b1;
        value = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        chk("two_pend2", {31'd0, pend}, 32'd1);
        wait_frame();
        chk("two_pend3", {31'd0, pend}, 32'd1);
        sample_frame(3, vecs[0].an_e, {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010},
                     4'b1111, "two");

        // Load coinciding with the boundary goes straight to the display.
        wait_frame();
        load = 1'b1;
        value = 16'h4321;
        @(negedge clk);
        load = 1'b0;
        chk("direct_pend", {31'd0, pend}, 32'd0);
        sample_frame(2, vecs[0].an_e, {7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111},
                     4'b1111, "direct");

        // Brightness duty.
        pwm_window(2'd1, 1);
        pwm_window(2'd2, 2);
        pwm_window(2'd0, 0);
        bright = 2'd3;

        // Reset mid-frame with a load pending.
        wait_frame();
        @(negedge clk);
        load = 1'b1;
        value = 16'h3333;
        @(negedge clk);
        load = 1'b0;
        chk("mrst_pend_pre", {31'd0, pend}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_an", {28'd0, an}, 32'hF);
        chk("mrst_seg", {25'd0, seg}, 32'h7F);
        chk("mrst_dp", {31'd0, dp}, 32'd1);
        chk("mrst_pend", {31'd0, pend}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_pend_rel", {31'd0, pend}, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        chk("mrst_frame_len", n, 15);
        sample_frame(3, vecs[7].an_e, vecs[7].seg_e, 4'b1111, "mrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
